// File: rtl/ifmem_bus_arb.sv
// Arbiter sharing one memory bus port between instruction fetch (IF) and the MEM stage.
// Define IFMEM_BUS_TIMEOUT_EN to add a bus_rdy watchdog that aborts hung transactions via bus_err.
module ifmem_bus_arb #(
    parameter int ADDR_W        = 30,
    parameter int DATA_W        = 32,
    parameter int MEM_BURST_MAX = 4,
    parameter int TIMEOUT       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_busy,
    input  logic              mem_req,
    input  logic              mem_rw,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_busy,
    output logic              bus_req,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_rdy,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_ACC  = 2'd1,
        MEM_ACC = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        burst_cnt;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic              mem_grant;
    logic              if_grant;
    logic              if_done;
    logic              mem_done;
    logic              abort;

    // MEM wins unless IF has already waited through MEM_BURST_MAX MEM grants.
    assign mem_grant = (state == IDLE) && mem_req &&
                       (!if_req || (burst_cnt < 4'(MEM_BURST_MAX)));
    assign if_grant  = (state == IDLE) && if_req && !mem_grant;
    assign if_done   = (state == IF_ACC)  && bus_rdy;
    assign mem_done  = (state == MEM_ACC) && bus_rdy;

`ifdef IFMEM_BUS_TIMEOUT_EN
    logic [7:0] wdog;

    assign abort   = (state != IDLE) && !bus_rdy && (wdog == 8'(TIMEOUT - 1));
    assign bus_err = abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog <= 8'd0;
        end else if (mem_grant || if_grant) begin
            wdog <= 8'd0;
        end else if ((state != IDLE) && !bus_rdy) begin
            wdog <= wdog + 8'd1;
        end
    end
`else
    assign abort   = 1'b0;
    assign bus_err = 1'b0;
`endif

    assign if_busy  = if_req  && !(if_done  || ((state == IF_ACC)  && abort));
    assign mem_busy = mem_req && !(mem_done || ((state == MEM_ACC) && abort));

    // Read data is passed straight through in the completing cycle, then held.
    always_comb begin
        if_rdata = if_rdata_q;
        if (if_done) begin
            if_rdata = bus_rdata;
        end else if ((state == IF_ACC) && abort) begin
            if_rdata = '0;
        end
    end

    always_comb begin
        mem_rdata = mem_rdata_q;
        if (mem_done) begin
            mem_rdata = bus_rdata;
        end else if ((state == MEM_ACC) && abort) begin
            mem_rdata = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bus_req     <= 1'b0;
            bus_rw      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            burst_cnt   <= 4'd0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_grant) begin
                        state     <= MEM_ACC;
                        bus_req   <= 1'b1;
                        bus_rw    <= mem_rw;
                        bus_addr  <= mem_addr;
                        bus_wdata <= mem_wdata;
                        if (!if_req) begin
                            burst_cnt <= 4'd0;
                        end else if (burst_cnt < 4'(MEM_BURST_MAX)) begin
                            burst_cnt <= burst_cnt + 4'd1;
                        end
                    end else if (if_grant) begin
                        state     <= IF_ACC;
                        bus_req   <= 1'b1;
                        bus_rw    <= 1'b0;
                        bus_addr  <= if_addr;
                        burst_cnt <= 4'd0;
                    end else begin
                        burst_cnt <= 4'd0;
                    end
                end
                IF_ACC: begin
                    if (bus_rdy) begin
                        state      <= IDLE;
                        bus_req    <= 1'b0;
                        if_rdata_q <= bus_rdata;
                    end else if (abort) begin
                        state      <= IDLE;
                        bus_req    <= 1'b0;
                        if_rdata_q <= '0;
                    end
                end
                MEM_ACC: begin
                    if (bus_rdy) begin
                        state       <= IDLE;
                        bus_req     <= 1'b0;
                        mem_rdata_q <= bus_rdata;
                    end else if (abort) begin
                        state       <= IDLE;
                        bus_req     <= 1'b0;
                        mem_rdata_q <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifmem_bus_arb.sv
// Scoreboard bench for ifmem_bus_arb: stimulus queues expected bus transactions,
// a monitor pops and compares them as the DUT completes each one.
module tb_ifmem_bus_arb;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_busy;
    logic              mem_req;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_busy;
    logic              bus_req;
    logic              bus_rw;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_rdy;
    logic              bus_err;

    always #5 clk = ~clk;

    ifmem_bus_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BURST_MAX(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_busy(if_busy),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy),
        .bus_req(bus_req), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_rdy(bus_rdy), .bus_err(bus_err)
    );

    typedef struct {
        logic              is_if;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
    } txn_t;

    typedef struct {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mreq_t;

    txn_t  exp_q[$];
    mreq_t mem_vec[$];
    int    n_vec    = 0;
    int    n_fail   = 0;
    int    wait_cfg = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic is_if, input logic rw, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata);
        txn_t t;
        t.is_if = is_if;
        t.rw    = rw;
        t.addr  = addr;
        t.wdata = wdata;
        t.rdata = rdata;
        exp_q.push_back(t);
    endtask

    task automatic push_mem(input logic rw, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        mreq_t m;
        m.rw    = rw;
        m.addr  = addr;
        m.wdata = wdata;
        mem_vec.push_back(m);
    endtask

    task automatic load_mem(input mreq_t m);
        mem_rw    = m.rw;
        mem_addr  = m.addr;
        mem_wdata = m.wdata;
        mem_req   = 1'b1;
    endtask

    // Bus slave: ready after wait_cfg wait cycles, read data = {2'b00, addr} ^ C000_0000.
    task automatic bus_responder();
        int waits = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!bus_req) begin
                waits     = 0;
                bus_rdy   = 1'b0;
                bus_rdata = 32'hDEAD_BEEF;
            end else if (waits >= wait_cfg) begin
                bus_rdy   = 1'b1;
                bus_rdata = {2'b00, bus_addr} ^ 32'hC000_0000;
            end else begin
                bus_rdy   = 1'b0;
                bus_rdata = 32'hDEAD_BEEF;
                waits++;
            end
        end
    endtask

    task automatic monitor();
        txn_t e;
        forever begin
            @(negedge clk);
            if (reset && bus_req && (exp_q.size() > 0)) begin
                e = exp_q[0];
                check_output("bus_addr", 32'(bus_addr), 32'(e.addr));
                check_output("bus_rw", 32'(bus_rw), 32'(e.rw));
                if (e.rw) check_output("bus_wdata", bus_wdata, e.wdata);
                if (bus_rdy) begin
                    e = exp_q.pop_front();
                    check_output("if_done", 32'(if_req && !if_busy), 32'(e.is_if));
                    check_output("mem_done", 32'(mem_req && !mem_busy), 32'(!e.is_if));
                    if (e.is_if) begin
                        check_output("if_rdata", if_rdata, e.rdata);
                        check_output("mem_busy_other", 32'(mem_busy), 32'(mem_req));
                    end else begin
                        if (!e.rw) check_output("mem_rdata", mem_rdata, e.rdata);
                        check_output("if_busy_other", 32'(if_busy), 32'(if_req));
                    end
                end else begin
                    check_output("owner_busy_wait", 32'(e.is_if ? if_busy : mem_busy), 32'd1);
`ifndef IFMEM_BUS_TIMEOUT_EN
                    check_output("bus_err_wait", 32'(bus_err), 32'd0);
`endif
                end
            end else if (reset && bus_req && bus_rdy) begin
                check_output("unexpected_txn", 32'd1, 32'd0);
            end
        end
    endtask

    // Hold each request until its busy falls; MEM reloads from mem_vec back-to-back.
    task automatic run_until_idle(input int max_cycles);
        int   n = 0;
        logic ifd;
        logic md;
        while ((if_req || mem_req) && (n < max_cycles)) begin
            @(negedge clk);
            ifd = if_req && !if_busy;
            md  = mem_req && !mem_busy;
            @(posedge clk);
            #1;
            if (ifd) if_req = 1'b0;
            if (md) begin
                if (mem_vec.size() > 0) load_mem(mem_vec.pop_front());
                else mem_req = 1'b0;
            end
            n++;
        end
        check_output("run_timeout", 32'({if_req, mem_req}), 32'd0);
        if_req  = 1'b0;
        mem_req = 1'b0;
    endtask

    task automatic apply_stimulus();
        mreq_t m;
        // Reset: bus idle, busy mirrors the requests.
        repeat (2) @(negedge clk);
        check_output("rst_bus_req", 32'(bus_req), 32'd0);
        check_output("rst_bus_addr", 32'(bus_addr), 32'd0);
        check_output("rst_bus_rw", 32'(bus_rw), 32'd0);
        check_output("rst_bus_wdata", bus_wdata, 32'd0);
        check_output("rst_bus_err", 32'(bus_err), 32'd0);
        check_output("rst_if_rdata", if_rdata, 32'd0);
        check_output("rst_mem_rdata", mem_rdata, 32'd0);
        if_req  = 1'b1;
        mem_req = 1'b1;
        #1;
        check_output("rst_if_busy", 32'(if_busy), 32'd1);
        check_output("rst_mem_busy", 32'(mem_busy), 32'd1);
        @(negedge clk);
        check_output("rst_no_grant", 32'(bus_req), 32'd0);
        if_req  = 1'b0;
        mem_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // IF only, zero wait states.
        if_addr = 30'h99;
        push_exp(1'b1, 1'b0, 30'h99, 32'h0, 32'hC000_0099);
        if_req = 1'b1;
        run_until_idle(20);
        @(negedge clk);
        check_output("if_only_req_drop", 32'(bus_req), 32'd0);
        check_output("if_rdata_hold", if_rdata, 32'hC000_0099);

        // Simultaneous: MEM write first, then IF.
        if_addr = 30'h2A0;
        m.rw = 1'b1; m.addr = 30'h10; m.wdata = 32'hAA;
        push_exp(1'b0, 1'b1, 30'h10, 32'hAA, 32'h0);
        push_exp(1'b1, 1'b0, 30'h2A0, 32'h0, 32'hC000_02A0);
        load_mem(m);
        if_req = 1'b1;
        run_until_idle(40);

        // Starvation: four MEM grants, then IF, then the pending fifth MEM.
        m.rw = 1'b1; m.addr = 30'h100; m.wdata = 32'h1000;
        push_mem(1'b1, 30'h101, 32'h1001);
        push_mem(1'b0, 30'h102, 32'h0);
        push_mem(1'b1, 30'h103, 32'h1003);
        push_mem(1'b1, 30'h104, 32'h1004);
        push_exp(1'b0, 1'b1, 30'h100, 32'h1000, 32'h0);
        push_exp(1'b0, 1'b1, 30'h101, 32'h1001, 32'h0);
        push_exp(1'b0, 1'b0, 30'h102, 32'h0, 32'hC000_0102);
        push_exp(1'b0, 1'b1, 30'h103, 32'h1003, 32'h0);
        push_exp(1'b1, 1'b0, 30'h3F0, 32'h0, 32'hC000_03F0);
        push_exp(1'b0, 1'b1, 30'h104, 32'h1004, 32'h0);
        if_addr = 30'h3F0;
        load_mem(m);
        if_req = 1'b1;
        run_until_idle(80);

        // Burst counter is back to zero: MEM wins a fresh conflict.
        m.rw = 1'b0; m.addr = 30'h44; m.wdata = 32'h0;
        if_addr = 30'h55;
        push_exp(1'b0, 1'b0, 30'h44, 32'h0, 32'hC000_0044);
        push_exp(1'b1, 1'b0, 30'h55, 32'h0, 32'hC000_0055);
        load_mem(m);
        if_req = 1'b1;
        run_until_idle(40);

        // Five wait states on a MEM write and an IF fetch.
        wait_cfg = 5;
        m.rw = 1'b1; m.addr = 30'h77; m.wdata = 32'h1234_5678;
        push_exp(1'b0, 1'b1, 30'h77, 32'h1234_5678, 32'h0);
        load_mem(m);
        run_until_idle(20);
        if_addr = 30'h123;
        push_exp(1'b1, 1'b0, 30'h123, 32'h0, 32'hC000_0123);
        if_req = 1'b1;
        run_until_idle(20);

        // Reset in the middle of a MEM access.
        wait_cfg = 10;
        m.rw = 1'b0; m.addr = 30'h3C; m.wdata = 32'h0;
        push_exp(1'b0, 1'b0, 30'h3C, 32'h0, 32'h0);
        load_mem(m);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("midrst_bus_req", 32'(bus_req), 32'd0);
        check_output("midrst_bus_addr", 32'(bus_addr), 32'd0);
        check_output("midrst_mem_busy", 32'(mem_busy), 32'd1);
        check_output("midrst_mem_rdata", mem_rdata, 32'd0);
        exp_q.delete();
        mem_req = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        wait_cfg = 0;
        if_addr  = 30'h2AA;
        push_exp(1'b1, 1'b0, 30'h2AA, 32'h0, 32'hC000_02AA);
        if_req = 1'b1;
        run_until_idle(20);

`ifdef IFMEM_BUS_TIMEOUT_EN
        // Bus never ready: abort pulse in the 16th wait cycle.
        wait_cfg = 1000;
        if_addr  = 30'h0F;
        if_req   = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i < 16) begin
                check_output("to_no_err", 32'(bus_err), 32'd0);
            end else begin
                check_output("to_bus_err", 32'(bus_err), 32'd1);
                check_output("to_if_busy", 32'(if_busy), 32'd0);
                check_output("to_if_rdata", if_rdata, 32'd0);
            end
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
        @(negedge clk);
        check_output("to_bus_req", 32'(bus_req), 32'd0);
        check_output("to_err_pulse", 32'(bus_err), 32'd0);
        wait_cfg = 0;
`endif

        repeat (2) @(negedge clk);
        check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_req   = 1'b0;
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        bus_rdy   = 1'b0;
        bus_rdata = '0;
        fork
            bus_responder();
            monitor();
            apply_stimulus();
            begin
                #200000;
                n_fail++;
                $display("[TB] FAIL global_timeout: got expired, expected stimulus to finish");
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ifmem_bus_arb.md
Name: ifmem_bus_arb

Overview:
- Two-requester arbiter sharing the single memory bus port between instruction fetch (IF) and the MEM-stage data access.
- IF's if_busy output drives the fetch-stage stall.
- Sequences one bus transaction at a time: request, address phase, wait for ready, completion.
- MEM has priority, with a starvation limit that guarantees IF forward progress.

Parameters:
- ADDR_W, 30, word-address width (matches WORD_ADDR_W).
- DATA_W, 32, data width (matches WORD_DATA_W).
- MEM_BURST_MAX, 4, consecutive MEM grants allowed while IF waits; range 1..15.
- TIMEOUT, 16, cycles to wait for bus_rdy before abort; used only with the optional feature; range 2..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until completion.
- if_addr  in  ADDR_W  fetch word address.
- if_rdata  out  DATA_W  fetched instruction; valid in the completing cycle.
- if_busy  out  1  IF request pending and not completing this cycle.
- mem_req  in  1  data access request; held until completion.
- mem_rw  in  1  1 = write, 0 = read.
- mem_addr  in  ADDR_W  data word address.
- mem_wdata  in  DATA_W  write data.
- mem_rdata  out  DATA_W  read data; valid in the completing cycle.
- mem_busy  out  1  MEM request pending and not completing this cycle.
- bus_req  out  1  bus transaction active.
- bus_rw  out  1  1 = write.
- bus_addr  out  ADDR_W  bus address (registered).
- bus_wdata  out  DATA_W  bus write data (registered).
- bus_rdata  in  DATA_W  bus read data.
- bus_rdy  in  1  transaction complete this cycle.
- bus_err  out  1  one-cycle abort pulse; tied 0 when the optional feature is off.

Behaviour:
- States: IDLE, IF_ACC, MEM_ACC; 2-bit state register.
- Reset (reset == 0, asynchronous) values:
  - state = IDLE.
  - bus_req = 0, bus_rw = 0, bus_addr = 0, bus_wdata = 0, bus_err = 0.
  - burst_cnt = 0.
  - if_rdata and mem_rdata read 0 while in reset.
  - if_busy = if_req and mem_busy = mem_req, since no access can complete in IDLE.
- IDLE transitions:
  - mem_req and (not if_req or burst_cnt < MEM_BURST_MAX) -> MEM_ACC. Latch mem_addr, mem_wdata and mem_rw onto the bus registers; bus_req = 1 next cycle.
  - Else if_req -> IF_ACC. Latch if_addr; bus_rw = 0.
  - Else remain in IDLE.
- Starvation counter burst_cnt (4 bits):
  - +1 on each MEM grant while if_req is high, saturating at MEM_BURST_MAX.
  - Cleared on each IF grant and whenever if_req is low at a grant decision.
  - When burst_cnt == MEM_BURST_MAX with both requests high, IF is granted.
- IF_ACC / MEM_ACC completion:
  - bus_req held at 1 and bus_* outputs stable until bus_rdy == 1.
  - On bus_rdy: return to IDLE, bus_req = 0 next cycle.
  - Owner's rdata = bus_rdata combinationally in that cycle; its busy output falls in that cycle.
- Busy equations:
  - if_busy = if_req and not (state == IF_ACC and bus_rdy).
  - mem_busy likewise, for MEM_ACC.
- Minimum latency is 2 cycles per transaction: grant cycle in IDLE, then earliest bus_rdy in the following cycle. Back-to-back transactions therefore have one IDLE cycle between them.
- Non-owner busy stays high throughout the other requester's access.
- Requester deasserting req mid-access (protocol violation): the transaction still completes on the bus; the result is discarded.
- Reset asserted mid-access: bus_req drops immediately and the state returns to IDLE; the transaction is not retried.
- Address/data changes on the requester side after grant are ignored; latched values are used.
- rdata outputs hold the last completed value of their owner when not completing; reset to 0.

Optional Feature:
- Macro: IFMEM_BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counts cycles in IF_ACC/MEM_ACC without bus_rdy.
  - On reaching TIMEOUT: state -> IDLE, bus_req = 0, bus_err pulses 1 for one cycle.
  - The owner's busy falls in that pulse cycle and rdata = 0.
  - The watchdog clears on every grant.
- Not defined: no watchdog; a transaction waits indefinitely for bus_rdy; bus_err is constant 0.

Test Plan:
- IF only: if_req = 1, if_addr = 0x99, bus_rdy = 1 the cycle after grant, bus_rdata = 0x1 -> bus_addr = 0x99 and bus_req = 1 for 1 cycle; if_busy falls in cycle 2 with if_rdata = 0x1.
- Simultaneous requests: if_req = mem_req = 1, mem_rw = 1, mem_addr = 0x10, mem_wdata = 0xAA -> MEM granted first (bus_rw = 1, bus_wdata = 0xAA); IF granted after MEM completes with bus_addr = if_addr.
- Starvation: mem_req held continuously with 4 back-to-back MEM transactions, if_req = 1 throughout -> 5th grant goes to IF; burst_cnt returns to 0.
- Wait states: bus_rdy held 0 for 5 cycles, then 1 -> bus_req and bus_addr stable all 6 cycles; owner busy high until the 6th cycle.
- Reset mid-access: reset = 0 during MEM_ACC -> bus_req = 0 asynchronously; after release, a new if_req is granted from IDLE.
- With IFMEM_BUS_TIMEOUT_EN and TIMEOUT = 16, bus_rdy never asserted -> bus_err pulses in the 16th wait cycle; if_busy falls, if_rdata = 0, state returns to IDLE.
